// File: rtl/single_port_ram_arbiter.sv
// Two-requester round-robin sequencer for a single-port RAM with a shared tri-state data bus.
// Each transaction walks IDLE -> ACCESS -> RELEASE so the bus always gets a turnaround cycle.
module single_port_ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              done_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              ram_we,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic                op_we_reg, op_we_next;
    logic                owner_reg, owner_next;   // 0 = A, 1 = B
    logic                ptr_reg, ptr_next;       // 1 = B favoured on a tie
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [1:0]          gnt_reg, gnt_next;
    logic [1:0]          done_reg, done_next;
    logic                ram_we_reg, ram_we_next;
    logic                ram_en_reg, ram_en_next;
    logic                busy_reg, busy_next;
    logic                capture_rd;
    logic                win;
    logic [1:0]          req_vec;
    logic [DATA_W-1:0]   rdata_reg [2];

    assign req_vec = {req_b, req_a};

    always_comb begin
        state_next  = state_reg;
        op_we_next  = op_we_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        gnt_next    = '0;
        done_next   = '0;
        ram_we_next = 1'b0;
        ram_en_next = 1'b0;
        capture_rd  = 1'b0;
        win         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    // B wins when it is alone or when A went last.
                    win          = req_vec[1] && (!req_vec[0] || ptr_reg);
                    owner_next   = win;
                    op_we_next   = win ? we_b : we_a;
                    addr_next    = win ? addr_b : addr_a;
                    wdata_next   = win ? wdata_b : wdata_a;
                    gnt_next[win] = 1'b1;
                    ptr_next     = !win;
                    ram_we_next  = op_we_next;
                    ram_en_next  = !op_we_next;
                    state_next   = ACCESS;
                end
            end
            ACCESS: begin
                capture_rd           = !op_we_reg;
                done_next[owner_reg] = 1'b1;
                state_next           = RELEASE;
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_we_reg  <= 1'b0;
            owner_reg  <= 1'b0;
            ptr_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            ram_we_reg <= 1'b0;
            ram_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_we_reg  <= op_we_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            ram_we_reg <= ram_we_next;
            ram_en_reg <= ram_en_next;
            busy_reg   <= busy_next;
        end
    end

    // Read data is sampled off the bus at the edge that leaves ACCESS.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg[gi] <= '0;
            end else if (capture_rd && (owner_reg == 1'(gi))) begin
                rdata_reg[gi] <= ram_data;
            end
        end
    end

    // Only a write in ACCESS drives the bus; everything else leaves it to the RAM.
    assign ram_data = (state_reg == ACCESS && op_we_reg) ? wdata_reg : 'z;

    assign gnt_a    = gnt_reg[0];
    assign gnt_b    = gnt_reg[1];
    assign done_a   = done_reg[0];
    assign done_b   = done_reg[1];
    assign rdata_a  = rdata_reg[0];
    assign rdata_b  = rdata_reg[1];
    assign busy     = busy_reg;
    assign ram_we   = ram_we_reg;
    assign ram_en   = ram_en_reg;
    assign ram_addr = addr_reg;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Directed bench for single_port_ram_arbiter with a behavioural 8x16 RAM on a pulled-up shared bus.
module tb_single_port_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [2:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, done_a, gnt_b, done_b, busy, ram_we, ram_en;
    logic [15:0] rdata_a, rdata_b;
    logic [2:0]  ram_addr;
    tri1  [15:0] ram_data;

    int checks = 0;
    int errors = 0;
    int both_high = 0;

    // A released bus floats high through the pull, so it reads 16'hFFFF.
    localparam logic [15:0] BUS_FREE = 16'hFFFF;

    logic [15:0] mem [8] = '{default: '0};
    assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 'z;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;
    always @(negedge clk) if (ram_we && ram_en) both_high++;

    always #5 clk = ~clk;

    single_port_ram_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .done_a(done_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .done_b(done_b), .rdata_b(rdata_b),
        .busy(busy), .ram_we(ram_we), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL reset_gnt_a cyc%0d got %b want 0", i, gnt_a); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got %b want 0", i, busy); end
        end
        checks++; if (ram_we !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL reset_we_en got %b%b want 00", ram_we, ram_en); end
        checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
        checks++; if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", rdata_a, rdata_b); end
        checks++; if (done_a !== 1'b0 || done_b !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b want 000", done_a, done_b, gnt_b); end
        checks++; if (ram_data !== BUS_FREE) begin errors++; $display("FAIL reset_bus got %h want %h", ram_data, BUS_FREE); end
        rst = 1'b0;
        tick;
        checks++; if (gnt_a !== 1'b1 || busy !== 1'b1 || ram_en !== 1'b1) begin errors++; $display("FAIL first_grant got gnt=%b busy=%b en=%b want 111", gnt_a, busy, ram_en); end
        req_a = 1'b0;
        tick;
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL first_done got %b want 1", done_a); end
        tick;
        checks++; if (busy !== 1'b0 || done_a !== 1'b0 || rdata_a !== 16'h0) begin errors++; $display("FAIL first_idle got busy=%b done=%b rdata=%h want 0 0 0000", busy, done_a, rdata_a); end
        $display("txn reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single_a;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 16'hBEEF;
        tick;
        checks++; if (gnt_a !== 1'b1 || ram_we !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL wr_access got gnt=%b we=%b en=%b want 1 1 0", gnt_a, ram_we, ram_en); end
        checks++; if (ram_addr !== 3'd3 || ram_data !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got addr=%0d data=%h want 3 beef", ram_addr, ram_data); end
        req_a = 1'b0; wdata_a = 16'h0;
        tick;
        checks++; if (ram_we !== 1'b0 || done_a !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("FAIL wr_release got we=%b done=%b gnt=%b want 0 1 0", ram_we, done_a, gnt_a); end
        checks++; if (ram_data !== BUS_FREE || ram_addr !== 3'd3) begin errors++; $display("FAIL wr_release_bus got data=%h addr=%0d want ffff 3", ram_data, ram_addr); end
        tick;
        checks++; if (busy !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL wr_idle got busy=%b we=%b want 0 0", busy, ram_we); end
        $display("txn A write addr=3 data=beef");
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd3;
        tick;
        checks++; if (gnt_a !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_data !== 16'hBEEF) begin errors++; $display("FAIL rd_access got gnt=%b en=%b we=%b data=%h want 1 1 0 beef", gnt_a, ram_en, ram_we, ram_data); end
        req_a = 1'b0;
        tick;
        checks++; if (done_a !== 1'b1 || rdata_a !== 16'hBEEF || ram_en !== 1'b0) begin errors++; $display("FAIL rd_done got done=%b rdata=%h en=%b want 1 beef 0", done_a, rdata_a, ram_en); end
        tick;
        checks++; if (done_a !== 1'b0 || rdata_a !== 16'hBEEF) begin errors++; $display("FAIL rd_hold got done=%b rdata=%h want 0 beef", done_a, rdata_a); end
        $display("txn A read addr=3 rdata=%h", rdata_a);
    endtask

    task automatic test_reset_mid;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd3;
        tick;
        checks++; if (gnt_b !== 1'b1 || ram_en !== 1'b1) begin errors++; $display("FAIL mid_access got gnt_b=%b en=%b want 1 1", gnt_b, ram_en); end
        rst = 1'b1; req_b = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || ram_en !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL mid_reset got busy=%b en=%b done_b=%b want 0 0 0", busy, ram_en, done_b); end
        checks++; if (rdata_b !== 16'h0 || ram_addr !== 3'd0 || rdata_a !== 16'h0) begin errors++; $display("FAIL mid_reset_regs got rdata_b=%h addr=%0d rdata_a=%h want 0 0 0", rdata_b, ram_addr, rdata_a); end
        rst = 1'b0;
        tick;
        checks++; if (done_b !== 1'b0 || busy !== 1'b0 || rdata_b !== 16'h0) begin errors++; $display("FAIL mid_after got done_b=%b busy=%b rdata_b=%h want 0 0 0", done_b, busy, rdata_b); end
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 3'd3; addr_b = 3'd3;
        tick;
        checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL mid_ptr got gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b); end
        req_a = 1'b0; req_b = 1'b0;
        tick;
        checks++; if (done_a !== 1'b1 || rdata_a !== 16'hBEEF || done_b !== 1'b0) begin errors++; $display("FAIL mid_read got done_a=%b rdata_a=%h done_b=%b want 1 beef 0", done_a, rdata_a, done_b); end
        tick;
        $display("txn reset during B read, then A read rdata=%h", rdata_a);
    endtask

    task automatic test_cross;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd7; wdata_a = 16'h0A5A;
        tick;
        checks++; if (gnt_a !== 1'b1 || ram_data !== 16'h0A5A) begin errors++; $display("FAIL cross_wr got gnt=%b data=%h want 1 0a5a", gnt_a, ram_data); end
        req_a = 1'b0;
        tick; tick;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd7;
        tick;
        checks++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("FAIL cross_gnt got gnt_b=%b gnt_a=%b want 1 0", gnt_b, gnt_a); end
        req_b = 1'b0;
        tick;
        checks++; if (done_b !== 1'b1 || rdata_b !== 16'h0A5A || rdata_a !== 16'hBEEF) begin errors++; $display("FAIL cross_rd got done_b=%b rdata_b=%h rdata_a=%h want 1 0a5a beef", done_b, rdata_b, rdata_a); end
        tick;
        $display("txn A write addr=7, B read addr=7 rdata_b=%h", rdata_b);
    endtask

    task automatic test_simultaneous;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        addr_a = 3'd0; wdata_a = 16'h1111; addr_b = 3'd1; wdata_b = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (gnt_a !== (k % 2 == 0) || gnt_b !== (k % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got a=%b b=%b want a=%b", k, gnt_a, gnt_b, (k % 2 == 0)); end
            checks++; if (ram_we !== 1'b1 || ram_addr !== 3'(k % 2)) begin errors++; $display("FAIL rr_access%0d got we=%b addr=%0d want 1 %0d", k, ram_we, ram_addr, k % 2); end
            tick;
            checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got a=%b b=%b want 0 0", k, gnt_a, gnt_b); end
            tick;
            $display("txn rr grant %0d to %s", k, (k % 2 == 0) ? "A" : "B");
        end
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 3'd0; addr_b = 3'd1;
        tick;
        checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL rr_rd_gnt_a got %b want 1", gnt_a); end
        req_a = 1'b0;
        tick;
        checks++; if (done_a !== 1'b1 || rdata_a !== 16'h1111) begin errors++; $display("FAIL rr_rd_a got done=%b rdata=%h want 1 1111", done_a, rdata_a); end
        tick; tick;
        checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL rr_rd_gnt_b got %b want 1", gnt_b); end
        req_b = 1'b0;
        tick;
        checks++; if (done_b !== 1'b1 || rdata_b !== 16'h2222 || rdata_a !== 16'h1111) begin errors++; $display("FAIL rr_rd_b got done=%b rdata_b=%h rdata_a=%h want 1 2222 1111", done_b, rdata_b, rdata_a); end
        tick;
        $display("txn readback A=%h B=%h", rdata_a, rdata_b);
    endtask

    task automatic test_back_to_back;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd5; wdata_a = 16'h1234;
        tick;
        checks++; if (ram_we !== 1'b1 || ram_data !== 16'h1234) begin errors++; $display("FAIL b2b_wr got we=%b data=%h want 1 1234", ram_we, ram_data); end
        we_a = 1'b0;
        tick;
        checks++; if (ram_we !== 1'b0 || ram_en !== 1'b0 || ram_data !== BUS_FREE) begin errors++; $display("FAIL b2b_release got we=%b en=%b data=%h want 0 0 ffff", ram_we, ram_en, ram_data); end
        tick;
        checks++; if (ram_we !== 1'b0 || ram_en !== 1'b0 || ram_data !== BUS_FREE) begin errors++; $display("FAIL b2b_idle got we=%b en=%b data=%h want 0 0 ffff", ram_we, ram_en, ram_data); end
        tick;
        checks++; if (gnt_a !== 1'b1 || ram_en !== 1'b1 || ram_data !== 16'h1234) begin errors++; $display("FAIL b2b_rd got gnt=%b en=%b data=%h want 1 1 1234", gnt_a, ram_en, ram_data); end
        req_a = 1'b0;
        tick;
        checks++; if (done_a !== 1'b1 || rdata_a !== 16'h1234) begin errors++; $display("FAIL b2b_done got done=%b rdata=%h want 1 1234", done_a, rdata_a); end
        tick;
        checks++; if (both_high !== 0) begin errors++; $display("FAIL we_en_exclusive got %0d cycles want 0", both_high); end
        $display("txn back-to-back write/read addr=5 rdata=%h", rdata_a);
    endtask

    initial begin
        test_reset;
        test_single_a;
        test_reset_mid;
        test_cross;
        test_simultaneous;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
